// File: rtl/shade_sequencer.sv
// Frame sequencer feeding hit records to the shading unit and streaming RGB pixels in raster order.
// Optional SHADE_HITCOUNT_EN adds a per-frame hit_count output.
module shade_sequencer #(
  parameter int          DATA_WIDTH = 32,
  parameter int          OUT_WIDTH  = 24,
  parameter int          H_RES      = 640,
  parameter int          V_RES      = 480,
  parameter logic [OUT_WIDTH-1:0] BG_COLOUR = 24'h000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  frame_done,
  input  logic                  cfg_we,
  input  logic [DATA_WIDTH-1:0] cfg_lx,
  input  logic [DATA_WIDTH-1:0] cfg_ly,
  input  logic [DATA_WIDTH-1:0] cfg_lz,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_hit,
  input  logic [DATA_WIDTH-1:0] in_nx,
  input  logic [DATA_WIDTH-1:0] in_ny,
  input  logic [DATA_WIDTH-1:0] in_nz,
  output logic [DATA_WIDTH-1:0] sh_nx,
  output logic [DATA_WIDTH-1:0] sh_ny,
  output logic [DATA_WIDTH-1:0] sh_nz,
  output logic [DATA_WIDTH-1:0] sh_lx,
  output logic [DATA_WIDTH-1:0] sh_ly,
  output logic [DATA_WIDTH-1:0] sh_lz,
  input  logic [OUT_WIDTH-1:0]  sh_shade,
`ifdef SHADE_HITCOUNT_EN
  output logic [$clog2(H_RES*V_RES+1)-1:0] hit_count,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_sof,
  output logic                  out_eol
);

  localparam int XW  = $clog2(H_RES);
  localparam int YW  = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam int HCW = $clog2(H_RES*V_RES+1);
  localparam logic [XW-1:0] X_LAST = XW'(H_RES-1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_RES-1);
  localparam logic [DATA_WIDTH-1:0] LIGHT_Y_UNIT = DATA_WIDTH'(32'h0100_0000);

  typedef enum logic [1:0] {IDLE, ACCEPT, SHADE, OUTPUT} state_t;

  state_t                state_q, state_d;
  logic                  busy_q, busy_d;
  logic                  frame_done_q, frame_done_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_sof_q, out_sof_d;
  logic                  out_eol_q, out_eol_d;
  logic [OUT_WIDTH-1:0]  out_data_q, out_data_d;
  logic                  hit_q, hit_d;
  logic [DATA_WIDTH-1:0] sh_nx_q, sh_nx_d, sh_ny_q, sh_ny_d, sh_nz_q, sh_nz_d;
  logic [DATA_WIDTH-1:0] sh_lx_q, sh_lx_d, sh_ly_q, sh_ly_d, sh_lz_q, sh_lz_d;
  logic [DATA_WIDTH-1:0] shd_lx_q, shd_lx_d, shd_ly_q, shd_ly_d, shd_lz_q, shd_lz_d;
  logic [XW-1:0]         x_q, x_d;
  logic [YW-1:0]         y_q, y_d;
  logic [HCW-1:0]        cnt_q, cnt_d;
  logic [HCW-1:0]        hit_count_q, hit_count_d;

  always_comb begin
    state_d      = state_q;
    frame_done_d = 1'b0;
    out_sof_d    = out_sof_q;
    out_eol_d    = out_eol_q;
    out_data_d   = out_data_q;
    hit_d        = hit_q;
    sh_nx_d      = sh_nx_q;
    sh_ny_d      = sh_ny_q;
    sh_nz_d      = sh_nz_q;
    sh_lx_d      = sh_lx_q;
    sh_ly_d      = sh_ly_q;
    sh_lz_d      = sh_lz_q;
    shd_lx_d     = shd_lx_q;
    shd_ly_d     = shd_ly_q;
    shd_lz_d     = shd_lz_q;
    x_d          = x_q;
    y_d          = y_q;
    cnt_d        = cnt_q;
    hit_count_d  = hit_count_q;

    if (cfg_we) begin
      shd_lx_d = cfg_lx;
      shd_ly_d = cfg_ly;
      shd_lz_d = cfg_lz;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACCEPT;
          x_d     = '0;
          y_d     = '0;
          cnt_d   = '0;
          // A config write coinciding with start bypasses the shadow straight into the frame light.
          sh_lx_d = cfg_we ? cfg_lx : shd_lx_q;
          sh_ly_d = cfg_we ? cfg_ly : shd_ly_q;
          sh_lz_d = cfg_we ? cfg_lz : shd_lz_q;
        end
      end
      ACCEPT: begin
        if (in_valid && in_ready_q) begin
          state_d = SHADE;
          hit_d   = in_hit;
          sh_nx_d = in_nx;
          sh_ny_d = in_ny;
          sh_nz_d = in_nz;
          if (in_hit) cnt_d = cnt_q + HCW'(1);
        end
      end
      SHADE: begin
        state_d    = OUTPUT;
        out_data_d = hit_q ? sh_shade : BG_COLOUR;
        out_sof_d  = (x_q == '0) && (y_q == '0);
        out_eol_d  = (x_q == X_LAST);
      end
      OUTPUT: begin
        if (out_ready) begin
          if ((x_q == X_LAST) && (y_q == Y_LAST)) begin
            state_d      = IDLE;
            frame_done_d = 1'b1;
            hit_count_d  = cnt_q;
          end else begin
            state_d = ACCEPT;
            if (x_q == X_LAST) begin
              x_d = '0;
              y_d = y_q + YW'(1);
            end else begin
              x_d = x_q + XW'(1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d      = (state_d != IDLE);
    in_ready_d  = (state_d == ACCEPT);
    out_valid_d = (state_d == OUTPUT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_sof_q    <= 1'b0;
      out_eol_q    <= 1'b0;
      out_data_q   <= '0;
      hit_q        <= 1'b0;
      sh_nx_q      <= '0;
      sh_ny_q      <= '0;
      sh_nz_q      <= '0;
      sh_lx_q      <= '0;
      sh_ly_q      <= LIGHT_Y_UNIT;
      sh_lz_q      <= '0;
      shd_lx_q     <= '0;
      shd_ly_q     <= LIGHT_Y_UNIT;
      shd_lz_q     <= '0;
      x_q          <= '0;
      y_q          <= '0;
      cnt_q        <= '0;
      hit_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      out_sof_q    <= out_sof_d;
      out_eol_q    <= out_eol_d;
      out_data_q   <= out_data_d;
      hit_q        <= hit_d;
      sh_nx_q      <= sh_nx_d;
      sh_ny_q      <= sh_ny_d;
      sh_nz_q      <= sh_nz_d;
      sh_lx_q      <= sh_lx_d;
      sh_ly_q      <= sh_ly_d;
      sh_lz_q      <= sh_lz_d;
      shd_lx_q     <= shd_lx_d;
      shd_ly_q     <= shd_ly_d;
      shd_lz_q     <= shd_lz_d;
      x_q          <= x_d;
      y_q          <= y_d;
      cnt_q        <= cnt_d;
      hit_count_q  <= hit_count_d;
    end
  end

  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_sof    = out_sof_q;
  assign out_eol    = out_eol_q;
  assign sh_nx      = sh_nx_q;
  assign sh_ny      = sh_ny_q;
  assign sh_nz      = sh_nz_q;
  assign sh_lx      = sh_lx_q;
  assign sh_ly      = sh_ly_q;
  assign sh_lz      = sh_lz_q;

`ifdef SHADE_HITCOUNT_EN
  assign hit_count = hit_count_q;
`else
  logic unused_cnt;
  assign unused_cnt = ^{cnt_q, hit_count_q};
`endif

endmodule

// File: tb/tb_shade_sequencer.sv
// Testbench for shade_sequencer at H_RES=4, V_RES=2 with a stub shading unit derived from sh_n*.
// Hit counting is also checked when SHADE_HITCOUNT_EN is defined.
module tb_shade_sequencer;

  localparam int HR  = 4;
  localparam int VR  = 2;
  localparam int HCW = $clog2(HR*VR+1);

  logic        clk = 1'b0;
  logic        rst, start, cfg_we, in_valid, in_hit, out_ready;
  logic [31:0] cfg_lx, cfg_ly, cfg_lz, in_nx, in_ny, in_nz;
  logic        busy, frame_done, in_ready, out_valid, out_sof, out_eol;
  logic [31:0] sh_nx, sh_ny, sh_nz, sh_lx, sh_ly, sh_lz;
  logic [23:0] sh_shade, out_data;
`ifdef SHADE_HITCOUNT_EN
  logic [HCW-1:0] hit_count;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        hit;
    logic [31:0] nx;
    logic [31:0] ny;
    logic [31:0] nz;
    int          stall;
    logic [23:0] exp_data;
    logic        exp_sof;
    logic        exp_eol;
  } pix_t;

  pix_t frame_a[8];
  pix_t frame_b[8];
  pix_t frame_c[8];

  shade_sequencer #(
    .DATA_WIDTH(32), .OUT_WIDTH(24), .H_RES(HR), .V_RES(VR), .BG_COLOUR(24'h102030)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .frame_done(frame_done),
    .cfg_we(cfg_we), .cfg_lx(cfg_lx), .cfg_ly(cfg_ly), .cfg_lz(cfg_lz),
    .in_valid(in_valid), .in_ready(in_ready), .in_hit(in_hit),
    .in_nx(in_nx), .in_ny(in_ny), .in_nz(in_nz),
    .sh_nx(sh_nx), .sh_ny(sh_ny), .sh_nz(sh_nz),
    .sh_lx(sh_lx), .sh_ly(sh_ly), .sh_lz(sh_lz),
    .sh_shade(sh_shade),
`ifdef SHADE_HITCOUNT_EN
    .hit_count(hit_count),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sof(out_sof), .out_eol(out_eol)
  );

  always #5 clk = ~clk;

  // Stub shading unit: zero normals give A0B0C0, other normals perturb the colour.
  assign sh_shade = {sh_nx[7:0] ^ 8'hA0, sh_ny[7:0] ^ 8'hB0, sh_nz[7:0] ^ 8'hC0};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic begin_frame(input string tag);
    start = 1'b1;
    step();
    start = 1'b0;
    check_output({tag, " busy"}, busy, 1);
    check_output({tag, " in_ready"}, in_ready, 1);
  endtask

  task automatic apply_stimulus(input pix_t p, input bit last, input string tag);
    int k;
    logic [23:0] held;
    k = 0;
    while (!in_ready && k < 20) begin
      step();
      k++;
    end
    check_output({tag, " accept ready"}, in_ready, 1);
    in_valid = 1'b1;
    in_hit   = p.hit;
    in_nx    = p.nx;
    in_ny    = p.ny;
    in_nz    = p.nz;
    step();
    in_valid = 1'b0;
    check_output({tag, " shade in_ready"}, in_ready, 0);
    check_output({tag, " shade out_valid"}, out_valid, 0);
    step();
    check_output({tag, " out_valid"}, out_valid, 1);
    held = out_data;
    for (int s = 0; s < p.stall; s++) begin
      in_valid = 1'b1;
      in_hit   = 1'b1;
      check_output({tag, " stall valid"}, out_valid, 1);
      check_output({tag, " stall data"}, out_data, held);
      check_output({tag, " stall in_ready"}, in_ready, 0);
      step();
    end
    in_valid = 1'b0;
    check_output({tag, " data"}, out_data, p.exp_data);
    check_output({tag, " sof"}, out_sof, p.exp_sof);
    check_output({tag, " eol"}, out_eol, p.exp_eol);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_output({tag, " post valid"}, out_valid, 0);
    check_output({tag, " frame_done"}, frame_done, last);
    check_output({tag, " busy"}, busy, !last);
    if (!last) begin
      check_output({tag, " next ready"}, in_ready, 1);
    end else begin
      step();
      check_output({tag, " frame_done pulse"}, frame_done, 0);
    end
  endtask

  initial begin
    // Frame A: all hits with zero normals.
    frame_a[0] = '{1'b1, 32'h0, 32'h0, 32'h0, 0, 24'hA0B0C0, 1'b1, 1'b0};
    frame_a[1] = '{1'b1, 32'h0, 32'h0, 32'h0, 0, 24'hA0B0C0, 1'b0, 1'b0};
    frame_a[2] = '{1'b1, 32'h0, 32'h0, 32'h0, 0, 24'hA0B0C0, 1'b0, 1'b0};
    frame_a[3] = '{1'b1, 32'h0, 32'h0, 32'h0, 0, 24'hA0B0C0, 1'b0, 1'b1};
    frame_a[4] = '{1'b1, 32'h0, 32'h0, 32'h0, 0, 24'hA0B0C0, 1'b0, 1'b0};
    frame_a[5] = '{1'b1, 32'h0, 32'h0, 32'h0, 0, 24'hA0B0C0, 1'b0, 1'b0};
    frame_a[6] = '{1'b1, 32'h0, 32'h0, 32'h0, 0, 24'hA0B0C0, 1'b0, 1'b0};
    frame_a[7] = '{1'b1, 32'h0, 32'h0, 32'h0, 0, 24'hA0B0C0, 1'b0, 1'b1};
    // Frame B: hit/miss alternating, nonzero normals, a 5-cycle stall on pixel 2.
    frame_b[0] = '{1'b1, 32'h11, 32'h22, 32'h33, 0, 24'hB192F3, 1'b1, 1'b0};
    frame_b[1] = '{1'b0, 32'h55, 32'h66, 32'h77, 0, 24'h102030, 1'b0, 1'b0};
    frame_b[2] = '{1'b1, 32'h11, 32'h22, 32'h33, 5, 24'hB192F3, 1'b0, 1'b0};
    frame_b[3] = '{1'b0, 32'h55, 32'h66, 32'h77, 0, 24'h102030, 1'b0, 1'b1};
    frame_b[4] = '{1'b1, 32'h0F, 32'h0F, 32'h0F, 0, 24'hAFBFCF, 1'b0, 1'b0};
    frame_b[5] = '{1'b0, 32'h55, 32'h66, 32'h77, 0, 24'h102030, 1'b0, 1'b0};
    frame_b[6] = '{1'b1, 32'h11, 32'h22, 32'h33, 0, 24'hB192F3, 1'b0, 1'b0};
    frame_b[7] = '{1'b0, 32'h55, 32'h66, 32'h77, 0, 24'h102030, 1'b0, 1'b1};
    // Frame C: five hits out of eight.
    frame_c[0] = '{1'b1, 32'h0,  32'h0,  32'h0,  0, 24'hA0B0C0, 1'b1, 1'b0};
    frame_c[1] = '{1'b0, 32'h55, 32'h55, 32'h55, 0, 24'h102030, 1'b0, 1'b0};
    frame_c[2] = '{1'b1, 32'h0,  32'h0,  32'h0,  0, 24'hA0B0C0, 1'b0, 1'b0};
    frame_c[3] = '{1'b1, 32'h0,  32'h0,  32'h0,  0, 24'hA0B0C0, 1'b0, 1'b1};
    frame_c[4] = '{1'b0, 32'h55, 32'h55, 32'h55, 0, 24'h102030, 1'b0, 1'b0};
    frame_c[5] = '{1'b1, 32'h0,  32'h0,  32'h0,  0, 24'hA0B0C0, 1'b0, 1'b0};
    frame_c[6] = '{1'b0, 32'h55, 32'h55, 32'h55, 0, 24'h102030, 1'b0, 1'b0};
    frame_c[7] = '{1'b1, 32'h0,  32'h0,  32'h0,  0, 24'hA0B0C0, 1'b0, 1'b1};

    rst = 1'b1; start = 1'b0; cfg_we = 1'b0; in_valid = 1'b0; in_hit = 1'b0; out_ready = 1'b0;
    cfg_lx = '0; cfg_ly = '0; cfg_lz = '0; in_nx = '0; in_ny = '0; in_nz = '0;
    step();
    step();
    rst = 1'b0;
    check_output("reset busy", busy, 0);
    check_output("reset out_valid", out_valid, 0);
    check_output("reset in_ready", in_ready, 0);
    check_output("reset frame_done", frame_done, 0);
    check_output("reset out_data", out_data, 0);
    check_output("reset sh_lx", sh_lx, 32'h0);
    check_output("reset sh_ly", sh_ly, 32'h0100_0000);
    check_output("reset sh_lz", sh_lz, 32'h0);
    check_output("reset sh_nx", sh_nx, 32'h0);
`ifdef SHADE_HITCOUNT_EN
    check_output("reset hit_count", hit_count, 0);
`endif

    begin_frame("A start");
    check_output("A sh_lx", sh_lx, 32'h0);
    check_output("A sh_ly", sh_ly, 32'h0100_0000);
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        start = 1'b1;
        step();
        start = 1'b0;
      end
      apply_stimulus(frame_a[i], i == 7, $sformatf("A%0d", i));
    end
`ifdef SHADE_HITCOUNT_EN
    check_output("A hit_count", hit_count, 8);
`endif

    begin_frame("B start");
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        cfg_we = 1'b1;
        cfg_lx = 32'h0080_0000;
        cfg_ly = 32'h0100_0000;
        cfg_lz = 32'h0;
        step();
        cfg_we = 1'b0;
        check_output("B mid cfg sh_lx", sh_lx, 32'h0);
`ifdef SHADE_HITCOUNT_EN
        check_output("B hold hit_count", hit_count, 8);
`endif
      end
      apply_stimulus(frame_b[i], i == 7, $sformatf("B%0d", i));
    end
    check_output("B end sh_lx", sh_lx, 32'h0);
`ifdef SHADE_HITCOUNT_EN
    check_output("B hit_count", hit_count, 4);
`endif

    begin_frame("C start");
    check_output("C sh_lx", sh_lx, 32'h0080_0000);
    check_output("C sh_ly", sh_ly, 32'h0100_0000);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(frame_a[i], 1'b0, $sformatf("C%0d", i));
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_output("midrst busy", busy, 0);
    check_output("midrst in_ready", in_ready, 0);
    check_output("midrst out_valid", out_valid, 0);
    check_output("midrst out_data", out_data, 0);
    check_output("midrst sh_lx", sh_lx, 32'h0);
    check_output("midrst sh_ly", sh_ly, 32'h0100_0000);
`ifdef SHADE_HITCOUNT_EN
    check_output("midrst hit_count", hit_count, 0);
`endif
    for (int i = 0; i < 3; i++) begin
      check_output("midrst frame_done", frame_done, 0);
      step();
    end

    cfg_we = 1'b1;
    cfg_lx = 32'h0;
    cfg_ly = 32'h0100_0000;
    cfg_lz = 32'h0123_4567;
    begin_frame("D start");
    cfg_we = 1'b0;
    check_output("D sh_lz", sh_lz, 32'h0123_4567);
    check_output("D sh_lx", sh_lx, 32'h0);
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(frame_c[i], i == 7, $sformatf("D%0d", i));
    end
`ifdef SHADE_HITCOUNT_EN
    check_output("D hit_count", hit_count, 5);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
